mem_bus_arbiter: RTL

- Shares the single block-wide data memory port between the instruction cache (read-only refills) and the data cache (refills and write-backs).
- Sits between both cache controllers and the data memory.
- Each cache sees a private memory-like port with READ/WRITE/ADDRESS/WRITEDATA/READDATA/BUSYWAIT semantics, so neither cache changes.
- The winning request is latched at grant and replayed to memory unchanged until memory completes.

---
 rtl/mem_bus_arbiter_pkg.sv | 15 +
 rtl/mem_bus_arbiter_rr_pick2.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the icache/dcache memory port arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2,
    StGap  = 2'd3
  } arb_state_e;

  // Encodings of last_grant and of the round-robin winner.
  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the requester not served last time wins.
module rr_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_grant_i,
  output logic winner_o,
  output logic valid_o
);

  always_comb begin
    valid_o = i_req_i | d_req_i;
    if (i_req_i && d_req_i) begin
      winner_o = (last_grant_i == GrantI) ? GrantD : GrantI;
    end else if (d_req_i) begin
      winner_o = GrantD;
    end else begin
      winner_o = GrantI;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one block-wide memory port between icache refills and dcache refills/write-backs.
// The winner's request is latched at grant and replayed to memory until it completes.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
  output logic [DATA_WIDTH-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
  output logic [DATA_WIDTH-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  arb_state_e            state_q;
  logic                  last_grant_q;
  logic                  op_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic i_req, d_req;
  logic winner, pick_valid;
  logic gnt_i, gnt_d;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

  rr_pick2 u_rr_pick2 (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .valid_o      (pick_valid)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            last_grant_q <= winner;
            if (winner == GrantD) begin
              // A simultaneous read+write from the dcache is treated as a write.
              op_write_q <= D_WRITE;
              addr_q     <= D_ADDRESS;
              wdata_q    <= D_WRITE ? D_WRITEDATA : '0;
              state_q    <= StGntD;
            end else begin
              op_write_q <= 1'b0;
              addr_q     <= I_ADDRESS;
              wdata_q    <= '0;
              state_q    <= StGntI;
            end
          end
        end
        StGntI, StGntD: begin
          if (!MEM_BUSYWAIT) begin
            state_q <= StGap;
          end
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_i = (state_q == StGntI);
  assign gnt_d = (state_q == StGntD);

  always_comb begin
    MEM_READ      = (gnt_i | gnt_d) & ~op_write_q;
    MEM_WRITE     = gnt_d & op_write_q;
    MEM_ADDRESS   = addr_q;
    MEM_WRITEDATA = wdata_q;
    // A requester is released only in its own completion cycle.
    I_BUSYWAIT    = i_req & ~(gnt_i & ~MEM_BUSYWAIT);
    D_BUSYWAIT    = d_req & ~(gnt_d & ~MEM_BUSYWAIT);
    I_READDATA    = MEM_READDATA;
    D_READDATA    = MEM_READDATA;
  end

endmodule
